// File: rtl/itype_pipe.sv
// itype_pipe: three-stage (Decode / Execute / Writeback) MIPS integer datapath.
//
// Owns the PC, the 32-entry register file, the ALU and branch resolution, and
// drives external instruction and data memories. Full forwarding from W into
// X plus write-through reads in D remove every stall; a taken branch squashes
// the one instruction sitting in D.
//
// Parameters
//   DATA_W      register / ALU / data-memory width (32 or 64)
//   PC_W        PC and instruction-address width (>= 8)
//   ADDR_W      data-memory word-address width (<= DATA_W)
//   RESET_PC    PC value loaded on reset
//   BRANCH_MODE 0 = absolute target imm, 1 = pc+1+sext(imm)
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   en            run enable; 0 freezes all architectural state
//   im_address    current PC to instruction memory
//   instruction   instruction at im_address (same cycle)
//   dm_q          data-memory read data, valid the cycle after its address
//   dm_we/dm_address/dm_d  data-memory write strobe, word address, write data
//   wb_we/wb_rd/wb_data    register write trace of the W stage
//   branch_taken  pulse when a taken branch redirects the PC
//   retired       instructions leaving W, wraps at 2^32
module itype_pipe #(
    parameter int              DATA_W      = 32,
    parameter int              PC_W        = 16,
    parameter int              ADDR_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              BRANCH_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [PC_W-1:0]   im_address,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] dm_q,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_d,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              branch_taken,
    output logic [31:0]       retired
);
    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL, OP_SRL, OP_PASS
    } alu_op_t;

    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rf [32];
    logic [31:0]       ret_q;

    // X stage registers
    logic              x_valid, x_use_imm, x_wr, x_lw, x_sw, x_beq, x_bne;
    alu_op_t           x_alu;
    logic [4:0]        x_rs, x_rt, x_dest, x_sa;
    logic [15:0]       x_imm16;
    logic [DATA_W-1:0] x_imm_val, x_rs_val, x_rt_val;
    logic [PC_W-1:0]   x_pc;

    // W stage registers
    logic              w_valid, w_wr, w_lw;
    logic [4:0]        w_rd;
    logic [DATA_W-1:0] w_res;

    // Captures load data on the first frozen cycle: the memory keeps following
    // dm_address (the X instruction), so a load in W would lose its data.
    logic              hold_valid;
    logic [DATA_W-1:0] hold_q;

    logic run;
    assign run = en & ~rst;

    // ---------------- W stage ----------------
    logic [DATA_W-1:0] load_q, w_value;
    logic              w_wr_act;
    assign load_q   = hold_valid ? hold_q : dm_q;
    assign w_value  = w_lw ? load_q : w_res;
    assign w_wr_act = w_valid & w_wr & (w_rd != 5'd0);

    assign wb_we   = w_wr_act & run;
    assign wb_rd   = w_rd;
    assign wb_data = w_value;
    assign retired = ret_q + {31'd0, w_valid & run};

    // ---------------- D stage ----------------
    logic [5:0]        d_op, d_func;
    logic [4:0]        d_rs, d_rt, d_rd, d_sa;
    logic [15:0]       d_imm;
    alu_op_t           d_alu;
    logic              d_use_imm, d_wr, d_lw, d_sw, d_beq, d_bne;
    logic [4:0]        d_dest;
    logic [DATA_W-1:0] d_imm_val, d_rs_val, d_rt_val;

    assign d_op   = instruction[31:26];
    assign d_rs   = instruction[25:21];
    assign d_rt   = instruction[20:16];
    assign d_rd   = instruction[15:11];
    assign d_sa   = instruction[10:6];
    assign d_func = instruction[5:0];
    assign d_imm  = instruction[15:0];

    always_comb begin
        d_alu     = OP_ADD;
        d_use_imm = 1'b0;
        d_wr      = 1'b0;
        d_dest    = d_rt;
        d_lw      = 1'b0;
        d_sw      = 1'b0;
        d_beq     = 1'b0;
        d_bne     = 1'b0;
        d_imm_val = DATA_W'($signed(d_imm));
        case (d_op)
            6'b000000: begin
                d_dest = d_rd;
                d_wr   = 1'b1;
                case (d_func)
                    6'b100000: d_alu = OP_ADD;
                    6'b100010: d_alu = OP_SUB;
                    6'b100100: d_alu = OP_AND;
                    6'b100101: d_alu = OP_OR;
                    6'b100110: d_alu = OP_XOR;
                    6'b101010: d_alu = OP_SLT;
                    6'b000000: d_alu = OP_SLL;
                    6'b000010: d_alu = OP_SRL;
                    default:   d_wr  = 1'b0;
                endcase
            end
            6'b001000, 6'b001001: begin d_use_imm = 1'b1; d_wr = 1'b1; end
            6'b001010: begin d_alu = OP_SLT; d_use_imm = 1'b1; d_wr = 1'b1; end
            6'b001100: begin
                d_alu = OP_AND; d_use_imm = 1'b1; d_wr = 1'b1;
                d_imm_val = DATA_W'(d_imm);
            end
            6'b001101: begin
                d_alu = OP_OR; d_use_imm = 1'b1; d_wr = 1'b1;
                d_imm_val = DATA_W'(d_imm);
            end
            6'b001110: begin
                d_alu = OP_XOR; d_use_imm = 1'b1; d_wr = 1'b1;
                d_imm_val = DATA_W'(d_imm);
            end
            6'b001111: begin
                d_alu = OP_PASS; d_use_imm = 1'b1; d_wr = 1'b1;
                d_imm_val = DATA_W'($signed({d_imm, 16'h0000}));
            end
            6'b100011: begin d_use_imm = 1'b1; d_wr = 1'b1; d_lw = 1'b1; end
            6'b101011: begin d_use_imm = 1'b1; d_sw = 1'b1; end
            6'b000100: d_beq = 1'b1;
            6'b000101: d_bne = 1'b1;
            default: ;
        endcase
    end

    // Register reads with write-through from the W stage.
    always_comb begin
        d_rs_val = rf[d_rs];
        d_rt_val = rf[d_rt];
        if (w_wr_act && w_rd == d_rs) d_rs_val = w_value;
        if (w_wr_act && w_rd == d_rt) d_rt_val = w_value;
        if (d_rs == 5'd0) d_rs_val = '0;
        if (d_rt == 5'd0) d_rt_val = '0;
    end

    // ---------------- X stage ----------------
    logic [DATA_W-1:0] x_a, x_b, alu_b, x_res;
    logic [SH_W-1:0]   shamt;
    logic              x_taken;
    logic [PC_W-1:0]   x_target;

    assign x_a   = (w_wr_act && w_rd == x_rs) ? w_value : x_rs_val;
    assign x_b   = (w_wr_act && w_rd == x_rt) ? w_value : x_rt_val;
    assign alu_b = x_use_imm ? x_imm_val : x_b;
    assign shamt = SH_W'(x_sa);

    always_comb begin
        x_res = x_a + alu_b;
        case (x_alu)
            OP_SUB:  x_res = x_a - alu_b;
            OP_AND:  x_res = x_a & alu_b;
            OP_OR:   x_res = x_a | alu_b;
            OP_XOR:  x_res = x_a ^ alu_b;
            OP_SLT:  x_res = ($signed(x_a) < $signed(alu_b)) ? DATA_W'(1) : '0;
            OP_SLL:  x_res = x_b << shamt;
            OP_SRL:  x_res = x_b >> shamt;
            OP_PASS: x_res = alu_b;
            default: x_res = x_a + alu_b;
        endcase
    end

    assign x_taken  = x_valid & ((x_beq & (x_a == x_b)) | (x_bne & (x_a != x_b)));
    assign x_target = (BRANCH_MODE == 1) ? (x_pc + PC_W'(1) + PC_W'($signed(x_imm16)))
                                         : PC_W'(x_imm16);

    assign im_address   = pc;
    assign branch_taken = x_taken & run;
    assign dm_we        = x_valid & x_sw & run;
    assign dm_address   = x_res[ADDR_W-1:0];
    assign dm_d         = x_b;

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            x_valid    <= 1'b0;
            w_valid    <= 1'b0;
            w_wr       <= 1'b0;
            w_lw       <= 1'b0;
            w_rd       <= '0;
            w_res      <= '0;
            ret_q      <= '0;
            hold_valid <= 1'b0;
            hold_q     <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (en) begin
            hold_valid <= 1'b0;
            pc         <= x_taken ? x_target : pc + PC_W'(1);
            // the instruction in D is squashed behind a taken branch
            x_valid    <= ~x_taken;
            x_alu      <= d_alu;
            x_use_imm  <= d_use_imm;
            x_wr       <= d_wr;
            x_lw       <= d_lw;
            x_sw       <= d_sw;
            x_beq      <= d_beq;
            x_bne      <= d_bne;
            x_rs       <= d_rs;
            x_rt       <= d_rt;
            x_dest     <= d_dest;
            x_sa       <= d_sa;
            x_imm16    <= d_imm;
            x_imm_val  <= d_imm_val;
            x_rs_val   <= d_rs_val;
            x_rt_val   <= d_rt_val;
            x_pc       <= pc;
            w_valid    <= x_valid;
            w_wr       <= x_valid & x_wr;
            w_lw       <= x_lw;
            w_rd       <= x_dest;
            w_res      <= x_res;
            ret_q      <= ret_q + {31'd0, w_valid};
            if (w_wr_act) rf[w_rd] <= w_value;
        end else if (!hold_valid) begin
            hold_valid <= 1'b1;
            hold_q     <= dm_q;
        end
    end
endmodule

// File: tb/tb_itype_pipe.sv
// tb_itype_pipe: directed program bench for itype_pipe.
// u_abs runs the main program with absolute branch targets and a small data
// memory model; u_rel runs a short loop with PC-relative branch targets.
module tb_itype_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;

    always #5 clk = ~clk;

    // absolute-target instance
    logic [15:0] im0;
    logic [31:0] ins0, dmq0, wbd0, ret0, dmd0;
    logic        dmwe0, wbwe0, bt0;
    logic [15:0] dma0;
    logic [4:0]  wbrd0;

    // relative-target instance
    logic [15:0] im1;
    logic [31:0] ins1, wbd1, ret1, dmd1;
    logic        dmwe1, wbwe1, bt1;
    logic [15:0] dma1;
    logic [4:0]  wbrd1;
    logic [31:0] zero_q = '0;

    logic [31:0] imem0 [256];
    logic [31:0] imem1 [256];
    logic [31:0] dmem  [256];

    assign ins0 = imem0[im0[7:0]];
    assign ins1 = imem1[im1[7:0]];

    always @(posedge clk) begin
        if (dmwe0) dmem[dma0[7:0]] <= dmd0;
        dmq0 <= dmem[dma0[7:0]];
    end

    itype_pipe #(.BRANCH_MODE(0)) u_abs (
        .clk(clk), .rst(rst), .en(en), .im_address(im0), .instruction(ins0),
        .dm_q(dmq0), .dm_we(dmwe0), .dm_address(dma0), .dm_d(dmd0),
        .wb_we(wbwe0), .wb_rd(wbrd0), .wb_data(wbd0),
        .branch_taken(bt0), .retired(ret0)
    );

    itype_pipe #(.BRANCH_MODE(1)) u_rel (
        .clk(clk), .rst(rst), .en(en), .im_address(im1), .instruction(ins1),
        .dm_q(zero_q), .dm_we(dmwe1), .dm_address(dma1), .dm_d(dmd1),
        .wb_we(wbwe1), .wb_rd(wbrd1), .wb_data(wbd1),
        .branch_taken(bt1), .retired(ret1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sa,
                                          input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sa[4:0], fn[5:0]};
    endfunction

    // per-cycle expectations for u_abs, cycle 0 = first cycle after reset release
    localparam int NC = 29;
    logic [15:0] e_pc   [NC];
    logic        e_we   [NC];
    logic [4:0]  e_rd   [NC];
    logic [31:0] e_data [NC];
    logic        e_dmwe [NC];
    logic        e_bt   [NC];

    task automatic set_wb(input int c, input int rd, input logic [31:0] d);
        e_we[c] = 1'b1; e_rd[c] = rd[4:0]; e_data[c] = d;
    endtask

    task automatic tick(input logic en_v, input logic rst_v);
        @(posedge clk);
        #1;
        en  = en_v;
        rst = rst_v;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem0[i] = '0; imem1[i] = '0; dmem[i] = '0;
        end
        dmem[16] = 32'hDEADBEEF;

        imem0[8'h00] = enc_i(8, 0, 1, 5);              // addi r1,r0,5
        imem0[8'h01] = enc_i(8, 1, 2, 3);              // addi r2,r1,3
        imem0[8'h02] = enc_r(2, 1, 3, 0, 'h20);        // add  r3,r2,r1
        imem0[8'h03] = enc_i(4, 0, 0, 'h20);           // beq  r0,r0,0x20
        imem0[8'h04] = enc_i(8, 0, 6, 99);             // squashed
        imem0[8'h20] = enc_i('h23, 0, 4, 'h10);        // lw   r4,0x10(r0)
        imem0[8'h21] = enc_i(8, 4, 5, 1);              // addi r5,r4,1
        imem0[8'h22] = enc_i('h2B, 2, 1, 4);           // sw   r1,4(r2)
        imem0[8'h23] = enc_i(5, 0, 0, 'h40);           // bne  r0,r0 (falls through)
        imem0[8'h24] = enc_r(5, 0, 7, 0, 'h2A);        // slt  r7,r5,r0
        imem0[8'h25] = enc_i('hF, 0, 8, 'h8000);       // lui  r8,0x8000
        imem0[8'h26] = enc_i('hD, 8, 9, 'hF00F);       // ori  r9,r8,0xF00F
        imem0[8'h27] = enc_r(0, 1, 10, 4, 'h00);       // sll  r10,r1,4
        imem0[8'h28] = enc_r(0, 8, 11, 31, 'h02);      // srl  r11,r8,31
        imem0[8'h29] = enc_r(1, 2, 12, 0, 'h22);       // sub  r12,r1,r2
        imem0[8'h2A] = enc_i('hC, 12, 13, 'hFFFF);     // andi r13,r12,0xFFFF
        imem0[8'h2B] = enc_r(1, 2, 14, 0, 'h26);       // xor  r14,r1,r2
        imem0[8'h2C] = 32'hFC00_0000;                  // unknown op: nop
        imem0[8'h2D] = enc_i(8, 0, 0, 7);              // addi r0,r0,7 (discarded)
        imem0[8'h2E] = enc_i(8, 0, 15, 'h77);          // addi r15,r0,0x77
        imem0[8'h2F] = enc_i(8, 15, 16, 1);            // addi r16,r15,1
        imem0[8'h30] = enc_i('h2B, 0, 16, 0);          // sw   r16,0(r0)
        imem0[8'h31] = enc_i('h2B, 0, 1, 0);           // sw   r1,0(r0)

        imem1[0] = enc_i(8, 0, 1, 1);                  // addi r1,r0,1
        imem1[1] = 32'hFC00_0000;                      // nop
        imem1[2] = enc_i(8, 0, 2, 2);                  // addi r2,r0,2
        imem1[3] = enc_i(4, 0, 0, 'hFFFE);             // beq  r0,r0,-2 -> 2
        imem1[4] = enc_i(8, 0, 3, 3);                  // squashed

        for (int c = 0; c < NC; c++) begin
            e_pc[c] = 16'h0020 + 16'(c - 5);
            e_we[c] = 1'b0; e_rd[c] = '0; e_data[c] = '0;
            e_dmwe[c] = 1'b0; e_bt[c] = 1'b0;
        end
        for (int c = 0; c < 5; c++) e_pc[c] = 16'(c);
        for (int c = 22; c < 27; c++) e_pc[c] = 16'h0031;
        e_pc[27] = 16'h0032;
        e_pc[28] = 16'h0000;
        set_wb(2, 1, 32'd5);
        set_wb(3, 2, 32'd8);
        set_wb(4, 3, 32'd13);
        e_bt[4] = 1'b1;
        set_wb(7, 4, 32'hDEADBEEF);
        set_wb(8, 5, 32'hDEADBEF0);
        e_dmwe[8] = 1'b1;
        set_wb(11, 7, 32'd1);
        set_wb(12, 8, 32'h80000000);
        set_wb(13, 9, 32'h8000F00F);
        set_wb(14, 10, 32'd80);
        set_wb(15, 11, 32'd1);
        set_wb(16, 12, 32'hFFFFFFFD);
        set_wb(17, 13, 32'h0000FFFD);
        set_wb(18, 14, 32'd13);
        set_wb(21, 15, 32'h77);
        set_wb(26, 16, 32'h78);
        e_dmwe[26] = 1'b1;

        // reset held three cycles
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            check("rst_pc", 64'(im0), 64'h0);
            check("rst_retired", 64'(ret0), 64'h0);
            check("rst_dm_we", 64'(dmwe0), 64'h0);
            check("rst_wb_we", 64'(wbwe0), 64'h0);
        end

        for (int c = 0; c < NC; c++) begin
            tick(!(c >= 22 && c <= 25), c == 27);
            check($sformatf("c%0d_pc", c), 64'(im0), 64'(e_pc[c]));
            check($sformatf("c%0d_wb_we", c), 64'(wbwe0), 64'(e_we[c]));
            if (e_we[c]) begin
                check($sformatf("c%0d_wb_rd", c), 64'(wbrd0), 64'(e_rd[c]));
                check($sformatf("c%0d_wb_data", c), 64'(wbd0), 64'(e_data[c]));
            end
            check($sformatf("c%0d_dm_we", c), 64'(dmwe0), 64'(e_dmwe[c]));
            check($sformatf("c%0d_branch", c), 64'(bt0), 64'(e_bt[c]));

            if (c == 8) begin
                check("sw_addr", 64'(dma0), 64'd12);
                check("sw_data", 64'(dmd0), 64'd5);
            end
            if (c == 21) check("retired_c21", 64'(ret0), 64'd19);
            if (c >= 22 && c <= 25) begin
                check("frz_retired", 64'(ret0), 64'd19);
                check("frz_wb_rd", 64'(wbrd0), 64'd16);
                check("frz_wb_data", 64'(wbd0), 64'h78);
            end
            if (c == 26) begin
                check("resume_addr", 64'(dma0), 64'd0);
                check("resume_data", 64'(dmd0), 64'h78);
                check("resume_retired", 64'(ret0), 64'd20);
            end
            if (c == 28) begin
                check("post_rst_retired", 64'(ret0), 64'd0);
                check("mem0_kept", 64'(dmem[0]), 64'h78);
            end

            // relative-target instance
            if (c == 2) begin
                check("rel_wb_rd", 64'(wbrd1), 64'd1);
                check("rel_wb_data", 64'(wbd1), 64'd1);
            end
            if (c == 4 || c == 7) check($sformatf("rel_bt_c%0d", c), 64'(bt1), 64'd1);
            if (c == 5 || c == 8) check($sformatf("rel_pc_c%0d", c), 64'(im1), 64'd2);
            if (c == 7) begin
                check("rel_wb2_rd", 64'(wbrd1), 64'd2);
                check("rel_wb2_data", 64'(wbd1), 64'd2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/itype_pipe.md
# itype_pipe

Parametrised three-stage (Decode / Execute / Writeback) MIPS integer datapath that supersedes the single-cycle I-type datapath. It owns the PC, register file, ALU and branch resolution, and drives the external instruction and data memories. Its additions are full forwarding, branch flush, a run-enable, selectable branch-target mode, and configurable data, PC and address widths. The instruction word stays fixed at 32 bits.

## Interface
- DATA_W, 32: register/ALU/data-memory width; legal values 32 or 64.
- PC_W, 16: PC and instruction-address width; ≥ 8.
- ADDR_W, 16: data-memory word-address width; ≤ DATA_W.
- RESET_PC, 0: PC value loaded on reset.
- BRANCH_MODE, 0: 0 = absolute target `imm`; 1 = PC-relative target `pc+1+sext(imm)`.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; 0 freezes all state.
- im_address  out  PC_W  current PC to the instruction memory (word address).
- instruction  in  32  instruction at im_address, combinational same cycle.
- dm_q  in  DATA_W  data-memory read data, valid the cycle after its address.
- dm_we  out  1  data-memory write strobe.
- dm_address  out  ADDR_W  data-memory word address.
- dm_d  out  DATA_W  data-memory write data.
- wb_we  out  1  register write this cycle (retire trace).
- wb_rd  out  5  destination register being written.
- wb_data  out  DATA_W  value being written.
- branch_taken  out  1  one-cycle pulse when a taken branch redirects the PC.
- retired  out  32  count of instructions leaving W; wraps at 2^32.

## Operation
- Supported opcodes:
  - R-type (op 0) funcs: add 100000, sub 100010, and 100100, or 100101, xor 100110, slt 101010, sll 000000, srl 000010.
  - I-type: addi 001000, addiu 001001, slti 001010, andi 001100, ori 001101, xori 001110, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101.
  - Any other op/func is a NOP: no writes, no branch, but still retires.
- Immediate extension: zero-extended to DATA_W for andi/ori/xori; sign-extended for everything else.
- Operand and result rules:
  - lui result = sext(imm << 16).
  - Shift operand = ext(sa); shifts use the low log2(DATA_W) bits.
  - slt compares signed.
  - add/addi ignore overflow (no trap).
- Register 0 reads 0 and writes to it are discarded. The 32×DATA_W register file resets to all zeros.
- D stage: decodes `instruction` and reads rs/rt. If W writes the same register in the same cycle, the read returns the written value (write-through).
- X stage: applies forwarding, then ALU, branch compare and memory access.
  - Forwarding: if W is valid, writes a nonzero rd, and rd equals an X source register, the operand is W's value. For a load in W that value is dm_q.
  - lw/sw address = (rs + sext(imm))[ADDR_W-1:0].
  - sw drives dm_we=1, dm_address and dm_d=rt for exactly its X cycle.
- W stage: writes rd (rt for I-type) with the ALU result, or dm_q for lw.
- Branches resolve in X:
  - Taken when beq has equal operands, or bne has unequal operands.
  - The target is truncated or zero-extended to PC_W.
  - On taken: pc ← target, the instruction currently in D is squashed (never retires), branch_taken=1.
- There are no stall conditions; the forwarding above covers every dependency.

## Timing
- PC advances pc+1 (mod 2^PC_W) every enabled cycle unless a branch is taken.
- Per-instruction timeline: fetch/decode in cycle n, X in n+1, W in n+2. wb_* and the retired increment appear in n+2.
- Taken-branch penalty: 1 bubble. The target's fetch happens in the cycle after the branch's X cycle.
- Throughput: 1 instruction/cycle with no branches.
- en=0 holds all registers. dm_we, wb_we and branch_taken are forced 0; wb_rd/wb_data hold their values. Resuming continues exactly where it froze.
- rst=1 at a clock edge has the following effect:
  - pc ← RESET_PC, X and W made invalid, registers ← 0, retired ← 0.
  - During any cycle with rst=1, dm_we, wb_we and branch_taken are forced 0. This covers a store or branch in flight.
- First instruction after reset release retires 2 cycles after its fetch.
- retired increments by exactly 1 per valid W cycle and never counts a squashed slot.

## Test plan
- Reset: hold rst 3 cycles → im_address=0, retired=0, dm_we=0 throughout. Release with addi stream → im_address 0,1,2,…; first wb_we two cycles after release.
- Chain: addi r1,r0,5; addi r2,r1,3; add r3,r2,r1 → wb_data 5, 8, 13 on consecutive cycles, no bubbles.
- Load-use: memory word 0x10=0xDEADBEEF; lw r4,0x10(r0); addi r5,r4,1 → r4=0xDEADBEEF, then r5=0xDEADBEF0 on the next cycle.
- Store: r1=5, r2=8; sw r1,4(r2) → dm_we=1 for one cycle with dm_address=12, dm_d=5.
- Branch, BRANCH_MODE=0: beq r0,r0,0x20 at pc 3 → branch_taken pulse, next im_address=0x20, pc 4 instruction not retired. bne r0,r0 → falls through.
- Branch, BRANCH_MODE=1: beq r0,r0 at pc 3 with imm=-2 → target 2.
- Freeze and reset: en=0 for 4 cycles mid-stream → no state change, dm_we=0. rst asserted while sw is in X → dm_we=0, pc=RESET_PC next cycle.
